// File: rtl/axi_rd_slave_pkg.sv
// Shared AXI read-side types plus burst address helpers.
package axi_rd_slave_pkg;

    localparam int AXI_ID_W = 4;

    typedef enum logic [2:0] {
        AXI_SIZE_1B, AXI_SIZE_2B, AXI_SIZE_4B, AXI_SIZE_8B,
        AXI_SIZE_16B, AXI_SIZE_32B, AXI_SIZE_64B, AXI_SIZE_128B
    } axi_axsize_e;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED, AXI_BURST_INCR, AXI_BURST_WRAP, AXI_BURST_RSVD
    } axi_axburst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY, AXI_RESP_EXOKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR
    } axi_rwresp_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        axi_rwresp_e         resp;
        logic                last;
    } axi_r_tag_t;

    // Computed 64 bits wide; callers truncate to their address width, which
    // yields the same result as doing the arithmetic modulo that width.
    function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                  input axi_axsize_e size,
                                                  input logic [7:0] len,
                                                  input axi_axburst_e burst);
        logic [63:0] bytes, aligned, total, lower, nxt;
        bytes   = 64'd1 << size;
        aligned = addr & ~(bytes - 64'd1);
        total   = bytes * (64'(len) + 64'd1);
        lower   = addr & ~(total - 64'd1);
        nxt     = aligned + bytes;
        case (burst)
            AXI_BURST_FIXED: nxt = addr;
            AXI_BURST_WRAP:  if (nxt == lower + total) nxt = lower;
            default: ;
        endcase
        return nxt;
    endfunction

    function automatic logic axi_wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_rd_slave_skid_fifo.sv
// Two-entry FIFO of {tag, data} with the head held in flops for glitch-free R outputs.
// Push-side never overfills: the producer only issues when the credit check allows it.
module axi_rd_skid_fifo
    import axi_rd_slave_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  axi_r_tag_t        pushTag,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [1:0]        count,
    output axi_r_tag_t        headTag,
    output logic [DATA_W-1:0] headData
);

    axi_r_tag_t        tailTag;
    logic [DATA_W-1:0] tailData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 2'd0;
            headTag  <= '0;
            headData <= '0;
            tailTag  <= '0;
            tailData <= '0;
        end else if (push && pop) begin
            if (count == 2'd1) begin
                headTag  <= pushTag;
                headData <= pushData;
            end else begin
                headTag  <= tailTag;
                headData <= tailData;
                tailTag  <= pushTag;
                tailData <= pushData;
            end
        end else if (pop) begin
            headTag  <= tailTag;
            headData <= tailData;
            count    <= count - 2'd1;
        end else if (push) begin
            if (count == 2'd0) begin
                headTag  <= pushTag;
                headData <= pushData;
            end else begin
                tailTag  <= pushTag;
                tailData <= pushData;
            end
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read responder over a 1-cycle-latency word SRAM: AR in cycle T, mem_ren T+1, rvalid T+3.
// Slots issue only while FIFO + in-flight stays under two, so rready stalls throttle mem_ren.
module axi_rd_slave
    import axi_rd_slave_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF = $clog2(DATA_W / 8);
    localparam logic [2:0] OFF_SIZE = 3'(OFF);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e            state;
    logic [ID_W-1:0]   idReg;
    logic [ADDR_W-1:0] addrReg;
    logic [7:0]        lenReg;
    logic [7:0]        cnt;
    axi_axsize_e       sizeReg;
    axi_axburst_e      burstReg;
    axi_rwresp_e       respReg;
    axi_rwresp_e       arResp;
    logic              inflight;
    axi_r_tag_t        inflightTag;
    axi_r_tag_t        slotTag;
    axi_r_tag_t        headTag;
    logic [1:0]        fifoCount;
    logic              pop;
    logic              credit;
    logic              issue;

    assign pop     = rvalid && rready;
    assign credit  = ({1'b0, fifoCount} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    assign issue   = (state == ISSUE) && credit;
    assign mem_ren = issue && (respReg == AXI_RESP_OKAY);
    assign mem_addr = addrReg[MEM_AW+OFF-1:OFF];

    assign slotTag.id   = AXI_ID_W'(idReg);
    assign slotTag.resp = respReg;
    assign slotTag.last = (cnt == lenReg);

    // Slave errors take precedence over a decode miss.
    always_comb begin
        arResp = AXI_RESP_OKAY;
        if (araddr[ADDR_W-1:MEM_AW+OFF] != '0)
            arResp = AXI_RESP_DECERR;
        if ((arburst == AXI_BURST_RSVD) || (arsize > OFF_SIZE) ||
            ((arburst == AXI_BURST_WRAP) && !axi_wrap_len_ok(arlen)))
            arResp = AXI_RESP_SLVERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            arready     <= 1'b0;
            idReg       <= '0;
            addrReg     <= '0;
            lenReg      <= '0;
            cnt         <= '0;
            sizeReg     <= AXI_SIZE_1B;
            burstReg    <= AXI_BURST_FIXED;
            respReg     <= AXI_RESP_OKAY;
            inflight    <= 1'b0;
            inflightTag <= '0;
        end else begin
            inflight <= issue;
            if (issue)
                inflightTag <= slotTag;
            case (state)
                IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        idReg    <= arid;
                        addrReg  <= araddr;
                        lenReg   <= arlen;
                        sizeReg  <= axi_axsize_e'(arsize);
                        burstReg <= axi_axburst_e'(arburst);
                        respReg  <= arResp;
                        cnt      <= 8'd0;
                        arready  <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addrReg <= ADDR_W'(axi_next_addr(64'(addrReg), sizeReg, lenReg, burstReg));
                        cnt     <= cnt + 8'd1;
                        if (cnt == lenReg) begin
                            state   <= IDLE;
                            arready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axi_rd_skid_fifo #(
        .DATA_W(DATA_W)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .pushTag  (inflightTag),
        .pushData ((inflightTag.resp == AXI_RESP_OKAY) ? mem_rdata : '0),
        .pop      (pop),
        .count    (fifoCount),
        .headTag  (headTag),
        .headData (rdata)
    );

    assign rvalid = (fifoCount != 2'd0);
    assign rid    = ID_W'(headTag.id);
    assign rresp  = headTag.resp;
    assign rlast  = headTag.last;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed and randomized bursts against a formula-based beat model and a bench-side SRAM.
module tb_axi_rd_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        mem_ren;
    logic [11:0] mem_addr;
    logic [63:0] mem_rdata = '0;

    axi_rd_slave #(.ID_W(4), .ADDR_W(32), .DATA_W(64), .MEM_AW(12)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] memArr [0:4095];
    always @(posedge clk) if (mem_ren) mem_rdata <= memArr[mem_addr];

    typedef struct {
        int          cyc;
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       rQ[$];
    int          memCyc[$];
    logic [11:0] memAdr[$];
    int          nCmp = 0;
    int          nBad = 0;
    int          issuedCnt = 0, poppedCnt = 0, maxOcc = 0;
    logic        stallPrev = 1'b0;
    logic [63:0] hData;
    logic [6:0]  hCtl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Passive monitor: records memory reads, accepted beats, occupancy and R stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (stallPrev && rvalid) begin
                chk("r_stable_data", rdata, hData);
                chk("r_stable_ctl", {57'd0, rid, rresp, rlast}, {57'd0, hCtl});
            end
            stallPrev = rvalid && !rready;
            hData = rdata;
            hCtl = {rid, rresp, rlast};
            if (issuedCnt - poppedCnt > maxOcc) maxOcc = issuedCnt - poppedCnt;
            if (mem_ren) begin
                memCyc.push_back(cyc);
                memAdr.push_back(mem_addr);
                issuedCnt++;
            end
            if (rvalid && rready) begin
                rQ.push_back('{cyc: cyc, id: rid, data: rdata, resp: rresp, last: rlast});
                poppedCnt++;
            end
        end else begin
            stallPrev = 1'b0;
        end
    end

    // Beat i address straight from the burst definition (no iteration).
    function automatic logic [11:0] refWord(input logic [31:0] addr, input int size,
                                            input int len, input int burst, input int i);
        longint bytes, a, aligned, total, lower, b;
        bytes   = longint'(1) << size;
        a       = longint'(addr);
        aligned = a & ~(bytes - 1);
        total   = bytes * (len + 1);
        lower   = a & ~(total - 1);
        if (burst == 0 || i == 0) b = a;
        else if (burst == 1)      b = aligned + i * bytes;
        else                      b = lower + ((aligned - lower + i * bytes) % total);
        return 12'((b >> 3) & 'hFFF);
    endfunction

    function automatic logic [1:0] expResp(input logic [31:0] addr, input int size,
                                           input int len, input int burst);
        if (burst == 3 || size > 3 ||
            (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)))
            return 2'd2;
        if (addr[31:15] != 17'd0) return 2'd3;
        return 2'd0;
    endfunction

    task automatic doAr(input logic [3:0] id, input logic [31:0] addr, input int len,
                        input int size, input int burst, output int t);
        t = -1;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (arready) begin
                t = cyc;
                break;
            end
        end
        chk("ar_accepted", {63'd0, t >= 0}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic runBurst(input string nm, input logic [3:0] id, input logic [31:0] addr,
                            input int len, input int size, input int burst,
                            input int stallAfter, input int stallLen, input bit chkLat);
        int t;
        int stalled;
        int n;
        logic [1:0] er;
        logic [63:0] ed;
        stalled = 0;
        n = len + 1;
        er = expResp(addr, size, len, burst);
        rready = 1'b1;
        rQ.delete(); memCyc.delete(); memAdr.delete();
        issuedCnt = 0; poppedCnt = 0; maxOcc = 0;
        doAr(id, addr, len, size, burst, t);
        for (int k = 0; k < 400; k++) begin
            if (rQ.size() >= n) break;
            rready = !(rQ.size() >= stallAfter && stalled < stallLen);
            if (!rready) stalled++;
            @(posedge clk); #1;
        end
        rready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_nbeats"}, 64'(rQ.size()), 64'(n));
        for (int i = 0; i < n && i < rQ.size(); i++) begin
            ed = (er == 2'd0) ? memArr[refWord(addr, size, len, burst, i)] : 64'd0;
            chk({nm, "_rid"}, {60'd0, rQ[i].id}, {60'd0, id});
            chk({nm, "_rdata"}, rQ[i].data, ed);
            chk({nm, "_rresp"}, {62'd0, rQ[i].resp}, {62'd0, er});
            chk({nm, "_rlast"}, {63'd0, rQ[i].last}, {63'd0, i == n - 1});
            if (chkLat) chk({nm, "_rcycle"}, 64'(rQ[i].cyc), 64'(t + 3 + i));
        end
        chk({nm, "_nreads"}, 64'(memAdr.size()), (er == 2'd0) ? 64'(n) : 64'd0);
        if (er == 2'd0)
            for (int i = 0; i < n && i < memAdr.size(); i++)
                chk({nm, "_mem_addr"}, {52'd0, memAdr[i]}, {52'd0, refWord(addr, size, len, burst, i)});
        if (chkLat && memCyc.size() > 0)
            chk({nm, "_first_ren_cycle"}, 64'(memCyc[0]), 64'(t + 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [31:0] ra;
        int rl, rs, rb;
        for (int i = 0; i < 4096; i++) memArr[i] = {$urandom, $urandom};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_rlast", {63'd0, rlast}, 64'd0);
        chk("rst_rresp", {62'd0, rresp}, 64'd0);
        chk("rst_rid", {60'd0, rid}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_mem_ren", {63'd0, mem_ren}, 64'd0);
        chk("rst_mem_addr", {52'd0, mem_addr}, 64'd0);
        rst = 1'b0;
        #1;
        chk("arready_before_edge", {63'd0, arready}, 64'd0);
        @(posedge clk); #1;
        chk("arready_after_release", {63'd0, arready}, 64'd1);

        runBurst("incr", 4'd5, 32'h100, 3, 3, 1, 99, 0, 1'b1);
        chk("incr_addr0", {52'd0, memAdr[0]}, 64'h20);
        chk("incr_addr3", {52'd0, memAdr[3]}, 64'h23);

        runBurst("wrap", 4'd6, 32'h118, 3, 3, 2, 99, 0, 1'b1);
        chk("wrap_addr0", {52'd0, memAdr[0]}, 64'h23);
        chk("wrap_addr1", {52'd0, memAdr[1]}, 64'h20);

        runBurst("fixed", 4'd1, 32'h40, 2, 3, 0, 99, 0, 1'b1);
        chk("fixed_addr2", {52'd0, memAdr[2]}, 64'h08);

        runBurst("narrow", 4'd2, 32'h104, 3, 2, 1, 99, 0, 1'b1);
        chk("narrow_addr2", {52'd0, memAdr[2]}, 64'h21);

        runBurst("backpressure", 4'd7, 32'h400, 7, 3, 1, 2, 5, 1'b0);
        chk("bp_max_occupancy", 64'(maxOcc), 64'd2);

        runBurst("err_rsvd_burst", 4'd3, 32'h80, 1, 3, 3, 99, 0, 1'b1);
        runBurst("err_size16", 4'd4, 32'h80, 1, 4, 1, 99, 0, 1'b1);
        runBurst("err_wrap_len2", 4'd8, 32'h80, 2, 3, 2, 99, 0, 1'b1);
        runBurst("err_decode", 4'd9, 32'h8000, 1, 3, 1, 99, 0, 1'b1);

        for (int r = 0; r < 14; r++) begin
            rb = $urandom_range(0, 3);
            rs = $urandom_range(0, 4);
            rl = $urandom_range(0, 15);
            ra = $urandom_range(0, 32'h7FFF);
            if ($urandom_range(0, 7) == 0) ra = ra | 32'h0001_0000;
            runBurst("rnd", 4'($urandom), ra, rl, rs, rb,
                     $urandom_range(0, rl), $urandom_range(0, 6), 1'b0);
        end

        // Reset in the middle of a burst
        rQ.delete();
        doAr(4'd3, 32'h300, 7, 3, 1, t);
        for (int k = 0; k < 50; k++) begin
            if (rQ.size() >= 2) break;
            @(negedge clk);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("midrst_arready", {63'd0, arready}, 64'd0);
        chk("midrst_mem_ren", {63'd0, mem_ren}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_arready_after", {63'd0, arready}, 64'd1);
        chk("midrst_rvalid_after", {63'd0, rvalid}, 64'd0);
        runBurst("post_reset", 4'd9, 32'h200, 0, 3, 1, 99, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
